// File: rtl/dec3_to_8.sv
// Registered 3-to-8 one-hot decoder with enable and selectable output polarity.
// q_vld is a registered copy of en; outputs are idle while disabled or in reset.
module dec3_to_8 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i,
  input  logic       en,
  output logic [7:0] q,
  output logic       q_vld
);

  localparam logic [7:0] IdleVal = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0] dec_d;

  // Gate each line with en so an unknown index cannot leak into q while disabled.
  always_comb begin
    dec_d = '0;
    for (int k = 0; k < 8; k++) begin
      dec_d[k] = en & (i == 3'(k));
    end
    if (OUT_ACTIVE_LOW) begin
      dec_d = ~dec_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= IdleVal;
      q_vld <= 1'b0;
    end else begin
      q     <= dec_d;
      q_vld <= en;
    end
  end

endmodule

// File: tb/tb_dec3_to_8.sv
// Bench for dec3_to_8: active-high and active-low instances share stimulus;
// expected values are queued at drive time and checked one cycle later.
module tb_dec3_to_8;

  logic       clk;
  logic       rst_n;
  logic [2:0] i;
  logic       en;
  logic [7:0] q;
  logic       q_vld;
  logic [7:0] q_n;
  logic       q_vld_n;

  typedef struct packed {
    logic [7:0] qh;
    logic [7:0] ql;
    logic       vld;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_fail;

  dec3_to_8 #(.OUT_ACTIVE_LOW(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .en    (en),
    .q     (q),
    .q_vld (q_vld)
  );

  dec3_to_8 #(.OUT_ACTIVE_LOW(1'b1)) dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .en    (en),
    .q     (q_n),
    .q_vld (q_vld_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] idx, input logic e);
    exp_t r;
    r.qh  = e ? (8'd1 << idx) : 8'h00;
    r.ql  = ~r.qh;
    r.vld = e;
    return r;
  endfunction

  task automatic drive(input logic [2:0] idx, input logic e);
    @(negedge clk);
    i  = idx;
    en = e;
    sb.push_back(model(idx, e));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i     = 3'b101;
    en    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (q !== 8'h00 || q_vld !== 1'b0 || q_n !== 8'hFF || q_vld_n !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d: got q=%h vld=%b q_n=%h vld_n=%b, want 00 0 ff 0",
                 c, q, q_vld, q_n, q_vld_n);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(model(3'b101, 1'b1));
    @(posedge clk);
    #1;
    begin
      exp_t e = sb.pop_front();
      n_chk++;
      if (q !== e.qh || q_n !== e.ql || q_vld !== e.vld || q_vld_n !== e.vld) begin
        n_fail++;
        $display("FAIL reset_release: got q=%h q_n=%h vld=%b/%b, want %h %h %b",
                 q, q_n, q_vld, q_vld_n, e.qh, e.ql, e.vld);
      end
    end
  endtask

  task automatic test_disabled();
    for (int c = 0; c < 3; c++) begin
      drive(3'b101, 1'b0);
      @(posedge clk);
      #1;
      begin
        exp_t e = sb.pop_front();
        n_chk++;
        if (q !== e.qh || q_n !== e.ql || q_vld !== e.vld || q_vld_n !== e.vld) begin
          n_fail++;
          $display("FAIL disabled c=%0d: got q=%h q_n=%h vld=%b, want %h %h %b",
                   c, q, q_n, q_vld, e.qh, e.ql, e.vld);
        end
      end
    end
  endtask

  task automatic test_sweep();
    for (int k = 0; k < 8; k++) begin
      drive(3'(k), 1'b1);
      @(posedge clk);
      #1;
      begin
        exp_t e = sb.pop_front();
        n_chk++;
        if (q !== e.qh || q_n !== e.ql || q_vld !== e.vld || q_vld_n !== e.vld) begin
          n_fail++;
          $display("FAIL sweep i=%0d: got q=%h q_n=%h vld=%b, want %h %h %b",
                   k, q, q_n, q_vld, e.qh, e.ql, e.vld);
        end
        n_chk++;
        if ($countones(q) != 1 || $countones(~q_n) != 1) begin
          n_fail++;
          $display("FAIL onehot i=%0d: got q=%h q_n=%h, want exactly one active bit",
                   k, q, q_n);
        end
      end
    end
  endtask

  task automatic test_enable_toggle();
    logic pat [3] = '{1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 3; c++) begin
      drive(3'b011, pat[c]);
      @(posedge clk);
      #1;
      begin
        exp_t e = sb.pop_front();
        n_chk++;
        if (q !== e.qh || q_n !== e.ql || q_vld !== e.vld || q_vld_n !== e.vld) begin
          n_fail++;
          $display("FAIL en_toggle c=%0d: got q=%h q_n=%h vld=%b, want %h %h %b",
                   c, q, q_n, q_vld, e.qh, e.ql, e.vld);
        end
      end
    end
  endtask

  task automatic test_x_index();
    drive(3'bxxx, 1'b0);
    @(posedge clk);
    #1;
    begin
      exp_t e = sb.pop_front();
      n_chk++;
      if (q !== e.qh || q_n !== e.ql || q_vld !== e.vld) begin
        n_fail++;
        $display("FAIL x_index: got q=%h q_n=%h vld=%b, want %h %h %b",
                 q, q_n, q_vld, e.qh, e.ql, e.vld);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [6] = '{3'd6, 3'd1, 3'd7, 3'd0, 3'd4, 3'd2};
    for (int c = 0; c < 6; c++) begin
      drive(seq[c], 1'b1);
      @(posedge clk);
      #1;
      begin
        exp_t e = sb.pop_front();
        n_chk++;
        if (q !== e.qh || q_n !== e.ql || q_vld !== e.vld || q_vld_n !== e.vld) begin
          n_fail++;
          $display("FAIL b2b i=%0d: got q=%h q_n=%h vld=%b, want %h %h %b",
                   seq[c], q, q_n, q_vld, e.qh, e.ql, e.vld);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(3'd7, 1'b1);
    @(posedge clk);
    #1;
    begin
      exp_t e = sb.pop_front();
      n_chk++;
      if (q !== e.qh || q_n !== e.ql || q_vld !== e.vld) begin
        n_fail++;
        $display("FAIL pre_async: got q=%h q_n=%h vld=%b, want %h %h %b",
                 q, q_n, q_vld, e.qh, e.ql, e.vld);
      end
    end
    // Assert reset mid-cycle, well before the next rising edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (q !== 8'h00 || q_vld !== 1'b0 || q_n !== 8'hFF || q_vld_n !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got q=%h vld=%b q_n=%h vld_n=%b, want 00 0 ff 0",
               q, q_vld, q_n, q_vld_n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'd2, 1'b1);
    @(posedge clk);
    #1;
    begin
      exp_t e = sb.pop_front();
      n_chk++;
      if (q !== e.qh || q_n !== e.ql || q_vld !== e.vld || q_vld_n !== e.vld) begin
        n_fail++;
        $display("FAIL post_async: got q=%h q_n=%h vld=%b, want %h %h %b",
                 q, q_n, q_vld, e.qh, e.ql, e.vld);
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_disabled();
    test_sweep();
    test_enable_toggle();
    test_x_index();
    test_back_to_back();
    test_async_reset();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule
